// File: rtl/i2cmb_cmd_sequencer.sv
// i2cmb_cmd_sequencer: runs SET_BUS/START/address/data/STOP on the I2CMB core for one request, one done pulse each.
// Latency follows the core's irq and wb_ack_i; stalls on wr_valid and rd_ready, and accepts requests only when idle.
module i2cmb_cmd_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  CSR_INIT       = 8'hC0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [3:0] req_bus,
  input  logic [6:0] req_addr,
  input  logic [5:0] req_len,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic       done,
  output logic [2:0] status,
  output logic [1:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  output logic       wb_we_o,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_ack_i,
  input  logic       irq_i
);
  localparam logic [1:0] CSR = 2'd0, DPR = 2'd1, CMDR = 2'd2;
  localparam logic [7:0] C_WRITE = 8'd1, C_RD_ACK = 8'd2, C_RD_NAK = 8'd3;
  localparam logic [7:0] C_START = 8'd4, C_STOP = 8'd5, C_SET_BUS = 8'd6;
  localparam logic [2:0] ST_OK = 3'd0, ST_NAK_ADDR = 3'd1, ST_NAK_DATA = 3'd2;
  localparam logic [2:0] ST_ARB = 3'd3, ST_ERR = 3'd4, ST_TIMEOUT = 3'd5;

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_WB, S_BUS_CMD, S_START, S_ADDR_DPR, S_ADDR_CMD, S_BYTE,
    S_WR_WAIT, S_WR_CMD, S_RD_DPR, S_RD_OUT, S_STOP, S_WAIT, S_TO_INIT
  } state_t;
  typedef enum logic [2:0] {P_BUS, P_START, P_ADDR, P_WDATA, P_RDATA, P_STOP} phase_t;

  state_t      state, nxt;
  phase_t      phase;
  logic        rw;
  logic [6:0]  addr;
  logic [5:0]  cnt;
  logic [2:0]  code;
  logic        fin;
  logic [31:0] tmo;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_INIT;   nxt <= S_IDLE;   phase <= P_BUS;
      rw <= 1'b0;        addr <= '0;      cnt <= '0;
      code <= ST_OK;     fin <= 1'b0;     tmo <= '0;
      req_ready <= 1'b0; wr_ready <= 1'b0;
      rd_data <= '0;     rd_valid <= 1'b0;
      done <= 1'b0;      status <= '0;
      wb_adr_o <= '0;    wb_dat_o <= '0;  wb_we_o <= 1'b0;
      wb_cyc_o <= 1'b0;  wb_stb_o <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_INIT: begin
          wb_cyc_o <= 1'b1; wb_stb_o <= 1'b1; wb_we_o <= 1'b1; wb_adr_o <= CSR; wb_dat_o <= CSR_INIT;
          fin <= 1'b0; nxt <= S_IDLE; state <= S_WB;
        end
        S_IDLE: if (req_valid) begin
          rw <= req_rw; addr <= req_addr; cnt <= req_len; code <= ST_OK; req_ready <= 1'b0;
          wb_cyc_o <= 1'b1; wb_stb_o <= 1'b1; wb_we_o <= 1'b1; wb_adr_o <= DPR; wb_dat_o <= {4'h0, req_bus};
          nxt <= S_BUS_CMD; state <= S_WB;
        end
        S_WB: if (wb_ack_i) begin
          wb_cyc_o <= 1'b0; wb_stb_o <= 1'b0; wb_we_o <= 1'b0; tmo <= '0;
          if (wb_we_o) begin
            state <= nxt;
            if (nxt == S_IDLE) begin
              req_ready <= 1'b1;
              if (fin) begin done <= 1'b1; status <= code; end
            end
          end else if (wb_adr_o == DPR) begin
            rd_data <= wb_dat_i; rd_valid <= 1'b1; state <= S_RD_OUT;
          // CMDR status: AL, then ERR, then NAK, then DON; arbitration loss and errors skip STOP
          end else if (wb_dat_i[5]) begin
            done <= 1'b1; status <= ST_ARB; req_ready <= 1'b1; state <= S_IDLE;
          end else if (wb_dat_i[4] || wb_dat_i[7:4] == 4'h0) begin
            done <= 1'b1; status <= ST_ERR; req_ready <= 1'b1; state <= S_IDLE;
          end else if (wb_dat_i[6]) begin
            if (phase == P_ADDR) begin
              code <= ST_NAK_ADDR; state <= S_STOP;
            end else if (phase == P_WDATA || phase == P_RDATA) begin
              code <= ST_NAK_DATA; state <= S_STOP;
            end else begin
              done <= 1'b1; status <= ST_ERR; req_ready <= 1'b1; state <= S_IDLE;
            end
          end else begin
            case (phase)
              P_BUS:   state <= S_START;
              P_START: state <= S_ADDR_DPR;
              P_ADDR:  state <= (cnt == 6'd0) ? S_STOP : S_BYTE;
              P_WDATA: begin cnt <= cnt - 6'd1; state <= (cnt == 6'd1) ? S_STOP : S_BYTE; end
              P_RDATA: state <= S_RD_DPR;
              default: begin done <= 1'b1; status <= code; req_ready <= 1'b1; state <= S_IDLE; end
            endcase
          end
        end
        S_BUS_CMD: begin
          wb_cyc_o <= 1'b1; wb_stb_o <= 1'b1; wb_we_o <= 1'b1; wb_adr_o <= CMDR; wb_dat_o <= C_SET_BUS;
          phase <= P_BUS; nxt <= S_WAIT; state <= S_WB;
        end
        S_START: begin
          wb_cyc_o <= 1'b1; wb_stb_o <= 1'b1; wb_we_o <= 1'b1; wb_adr_o <= CMDR; wb_dat_o <= C_START;
          phase <= P_START; nxt <= S_WAIT; state <= S_WB;
        end
        S_ADDR_DPR: begin
          wb_cyc_o <= 1'b1; wb_stb_o <= 1'b1; wb_we_o <= 1'b1; wb_adr_o <= DPR; wb_dat_o <= {addr, rw};
          nxt <= S_ADDR_CMD; state <= S_WB;
        end
        S_ADDR_CMD: begin
          wb_cyc_o <= 1'b1; wb_stb_o <= 1'b1; wb_we_o <= 1'b1; wb_adr_o <= CMDR; wb_dat_o <= C_WRITE;
          phase <= P_ADDR; nxt <= S_WAIT; state <= S_WB;
        end
        S_BYTE: begin
          if (rw) begin
            wb_cyc_o <= 1'b1; wb_stb_o <= 1'b1; wb_we_o <= 1'b1; wb_adr_o <= CMDR;
            wb_dat_o <= (cnt == 6'd1) ? C_RD_NAK : C_RD_ACK;
            phase <= P_RDATA; nxt <= S_WAIT; state <= S_WB;
          end else begin
            wr_ready <= 1'b1; state <= S_WR_WAIT;
          end
        end
        S_WR_WAIT: if (wr_valid) begin
          wr_ready <= 1'b0;
          wb_cyc_o <= 1'b1; wb_stb_o <= 1'b1; wb_we_o <= 1'b1; wb_adr_o <= DPR; wb_dat_o <= wr_data;
          nxt <= S_WR_CMD; state <= S_WB;
        end
        S_WR_CMD: begin
          wb_cyc_o <= 1'b1; wb_stb_o <= 1'b1; wb_we_o <= 1'b1; wb_adr_o <= CMDR; wb_dat_o <= C_WRITE;
          phase <= P_WDATA; nxt <= S_WAIT; state <= S_WB;
        end
        S_RD_DPR: begin
          wb_cyc_o <= 1'b1; wb_stb_o <= 1'b1; wb_we_o <= 1'b0; wb_adr_o <= DPR; wb_dat_o <= '0;
          nxt <= S_RD_OUT; state <= S_WB;
        end
        S_RD_OUT: if (rd_ready) begin
          rd_valid <= 1'b0; cnt <= cnt - 6'd1;
          state <= (cnt == 6'd1) ? S_STOP : S_BYTE;
        end
        S_STOP: begin
          wb_cyc_o <= 1'b1; wb_stb_o <= 1'b1; wb_we_o <= 1'b1; wb_adr_o <= CMDR; wb_dat_o <= C_STOP;
          phase <= P_STOP; nxt <= S_WAIT; state <= S_WB;
        end
        S_WAIT: begin
          if (irq_i) begin
            wb_cyc_o <= 1'b1; wb_stb_o <= 1'b1; wb_we_o <= 1'b0; wb_adr_o <= CMDR; wb_dat_o <= '0;
            state <= S_WB;
          // a hung core is disabled and re-enabled before reporting the timeout
          end else if (tmo >= TIMEOUT_CYCLES - 1) begin
            wb_cyc_o <= 1'b1; wb_stb_o <= 1'b1; wb_we_o <= 1'b1; wb_adr_o <= CSR; wb_dat_o <= 8'h00;
            nxt <= S_TO_INIT; state <= S_WB;
          end else begin
            tmo <= tmo + 32'd1;
          end
        end
        S_TO_INIT: begin
          wb_cyc_o <= 1'b1; wb_stb_o <= 1'b1; wb_we_o <= 1'b1; wb_adr_o <= CSR; wb_dat_o <= CSR_INIT;
          fin <= 1'b1; code <= ST_TIMEOUT; nxt <= S_IDLE; state <= S_WB;
        end
        default: state <= S_INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_i2cmb_cmd_sequencer.sv
// Bench for i2cmb_cmd_sequencer: behavioural I2CMB core/slave model on the Wishbone side plus
// a scoreboard of expected register writes, read bytes and completion codes.
module tb_i2cmb_cmd_sequencer;
  localparam int TMO = 50;

  logic       clk = 1'b0, rst = 1'b1;
  logic       req_valid = 0, req_ready, req_rw = 0;
  logic [3:0] req_bus = 0;
  logic [6:0] req_addr = 0;
  logic [5:0] req_len = 0;
  logic [7:0] wr_data = 0, rd_data;
  logic       wr_valid = 0, wr_ready, rd_valid, rd_ready = 0, done;
  logic [2:0] status;
  logic [1:0] wb_adr_o;
  logic [7:0] wb_dat_o, wb_dat_i = 0;
  logic       wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i = 0, irq_i = 0;

  always #5 clk = ~clk;

  i2cmb_cmd_sequencer #(.TIMEOUT_CYCLES(TMO), .CSR_INIT(8'hC0)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_bus(req_bus), .req_addr(req_addr), .req_len(req_len), .wr_data(wr_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .done(done), .status(status), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .irq_i(irq_i));

  int checks = 0, failures = 0;
  int done_cnt = 0, ops_seen = 0, cyc = 0, last_cmdr_cyc = 0, done_cyc = 0;
  logic [9:0] exp_ops[$];
  logic [2:0] exp_st[$];
  logic [7:0] exp_rd[$], wr_q[$], rd_src[$], fixed_q[$];

  // scenario knobs for the core model
  int         cfg_nak_idx = -1;
  bit         cfg_no_irq = 0;
  logic [7:0] cfg_force_cmd = 8'hFF, cfg_force_stat = 8'h00;
  bit         stall_armed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // I2CMB core model: registers, irq after each command, status per slave behaviour
  logic [7:0] m_dpr = 0, m_stat = 0;
  int         irq_dly = 0, ack_wait = 0, byte_idx = 0;
  bit         expect_addr = 0;

  task automatic model_write(input logic [1:0] adr, input logic [7:0] dat);
    ops_seen++;
    check("wb_op_expected", exp_ops.size() > 0, 1);
    if (exp_ops.size() > 0) check("wb_write_op", {adr, dat}, exp_ops.pop_front());
    case (adr)
      2'd0: begin irq_i = 0; irq_dly = 0; expect_addr = 0; end
      2'd1: m_dpr = dat;
      2'd2: begin
        last_cmdr_cyc = cyc;
        m_stat = 8'h80;
        case (dat)
          8'd4: expect_addr = 1;
          8'd1: if (expect_addr) begin
                  expect_addr = 0; byte_idx = 0;
                  if (m_dpr[7:1] == 7'h7F) m_stat = 8'h40;
                end else begin
                  if (byte_idx == cfg_nak_idx) m_stat = 8'h40;
                  byte_idx++;
                end
          8'd2, 8'd3: m_dpr = (rd_src.size() > 0) ? rd_src.pop_front() : 8'hEE;
          default: ;
        endcase
        if (dat == cfg_force_cmd) m_stat = cfg_force_stat;
        if (!cfg_no_irq) irq_dly = $urandom_range(1, 4);
      end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (irq_dly > 0) begin irq_dly--; if (irq_dly == 0) irq_i = 1; end
    if (wb_ack_i) wb_ack_i = 0;
    else if (wb_cyc_o && wb_stb_o) begin
      if (ack_wait > 0) ack_wait--;
      else begin
        wb_ack_i = 1;
        ack_wait = $urandom_range(0, 2);
        if (wb_we_o) model_write(wb_adr_o, wb_dat_o);
        else if (wb_adr_o == 2'd2) begin wb_dat_i = m_stat; irq_i = 0; end
        else wb_dat_i = m_dpr;
      end
    end
  end

  // monitor: completion codes and read bytes
  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++; done_cyc = cyc;
      check("status_expected", exp_st.size() > 0, 1);
      if (exp_st.size() > 0) check("status", status, exp_st.pop_front());
    end
    if (!rst && rd_valid && rd_ready) begin
      check("rd_expected", exp_rd.size() > 0, 1);
      if (exp_rd.size() > 0) check("rd_data", rd_data, exp_rd.pop_front());
    end
  end

  // byte-stream drivers: wr bytes offered early (must be ignored until a write phase), random rd_ready
  bit hs;
  int stall_left = 0;
  initial forever begin
    @(negedge clk); hs = wr_valid && wr_ready;
    @(posedge clk); #1;
    if (hs && wr_q.size() > 0) void'(wr_q.pop_front());
    if (wr_q.size() > 0 && $urandom_range(0, 3) != 0) begin wr_valid = 1; wr_data = wr_q[0]; end
    else begin wr_valid = 0; wr_data = 8'($urandom); end
    if (rd_valid && stall_armed) begin stall_left = 5; stall_armed = 0; end
    if (stall_left > 0) begin rd_ready = 0; stall_left--; end
    else rd_ready = ($urandom_range(0, 2) != 0);
  end

  task automatic push_op(input logic [1:0] adr, input logic [7:0] dat);
    exp_ops.push_back({adr, dat});
  endtask

  function automatic logic [7:0] next_byte();
    if (fixed_q.size() > 0) return fixed_q.pop_front();
    return 8'($urandom);
  endfunction

  // expected register traffic and completion code, derived from the request and scenario
  task automatic issue(input bit rw, input logic [3:0] bus, input logic [6:0] addr, input int len,
                       output bit acc_in_done);
    logic [2:0] st;
    logic [7:0] b;
    int n;
    push_op(2'd1, {4'h0, bus}); push_op(2'd2, 8'h06);
    if (cfg_no_irq) begin push_op(2'd0, 8'h00); push_op(2'd0, 8'hC0); st = 3'd5; end
    else if (cfg_force_cmd == 8'h06) st = 3'd4;
    else begin
      push_op(2'd2, 8'h04);
      if (cfg_force_cmd == 8'h04) st = 3'd3;
      else begin
        push_op(2'd1, {addr, rw}); push_op(2'd2, 8'h01);
        st = (addr == 7'h7F) ? 3'd1 : 3'd0;
        for (int k = 0; k < len && st == 3'd0; k++) begin
          b = next_byte();
          if (rw) begin
            push_op(2'd2, (k == len - 1) ? 8'h03 : 8'h02);
            rd_src.push_back(b); exp_rd.push_back(b);
          end else begin
            wr_q.push_back(b); push_op(2'd1, b); push_op(2'd2, 8'h01);
            if (k == cfg_nak_idx) st = 3'd2;
          end
        end
        push_op(2'd2, 8'h05);
        if (cfg_force_cmd == 8'h05) st = 3'd4;
      end
    end
    exp_st.push_back(st);
    @(posedge clk); #1;
    req_valid = 1; req_rw = rw; req_bus = bus; req_addr = addr; req_len = 6'(len);
    n = 0;
    while (n < 20000) begin @(negedge clk); if (req_ready) break; n++; end
    check("req_accepted", req_ready, 1);
    acc_in_done = done;
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 20000) begin @(negedge clk); n++; end
    check("done_seen", done_cnt >= target, 1);
    @(negedge clk);
    check("ops_drained", exp_ops.size(), 0);
    check("rd_drained", exp_rd.size(), 0);
    check("wr_consumed", wr_q.size(), 0);
    cfg_nak_idx = -1; cfg_no_irq = 0; cfg_force_cmd = 8'hFF;
  endtask

  task automatic run_req(input bit rw, input logic [3:0] bus, input logic [6:0] addr, input int len);
    int tgt;
    bit a;
    tgt = done_cnt + 1;
    issue(rw, bus, addr, len, a);
    wait_done(tgt);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 1000) begin @(negedge clk); n++; end
    check("ready_after_init", req_ready, 1);
  endtask

  initial begin
    int tgt, d_before;
    bit a;
    push_op(2'd0, 8'hC0);
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_done_status", {done, status}, 0);
    check("rst_wb", {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o}, 0);
    check("rst_streams", {wr_ready, rd_valid, rd_data}, 0);
    rst = 0;
    wait_ready();
    check("init_csr_written", exp_ops.size(), 0);

    fixed_q = '{8'hA5, 8'h5A, 8'hFF};
    run_req(0, 4'd2, 7'h22, 3);
    fixed_q = '{8'h11, 8'h22};
    stall_armed = 1;
    run_req(1, 4'd0, 7'h22, 2);
    run_req(0, 4'd1, 7'h7F, 2);
    cfg_nak_idx = 1;
    run_req(0, 4'd3, 7'h22, 3);
    run_req(0, 4'd4, 7'h50, 0);
    cfg_force_cmd = 8'h04; cfg_force_stat = 8'h20;
    run_req(0, 4'd0, 7'h10, 2);
    cfg_force_cmd = 8'h06; cfg_force_stat = 8'h10;
    run_req(1, 4'd5, 7'h10, 2);
    cfg_force_cmd = 8'h05; cfg_force_stat = 8'h00;
    run_req(0, 4'd6, 7'h33, 0);

    cfg_no_irq = 1;
    run_req(0, 4'd1, 7'h22, 1);
    check("timeout_lo", (done_cyc - last_cmdr_cyc) >= TMO + 4, 1);
    check("timeout_hi", (done_cyc - last_cmdr_cyc) <= TMO + 8, 1);

    run_req(1, 4'd7, 7'h45, 63);
    for (int i = 0; i < 8; i++)
      run_req(1'($urandom), 4'($urandom), 7'($urandom_range(0, 126)), $urandom_range(0, 6));

    // back-to-back: second request waits in req_valid and is taken in the done cycle
    tgt = done_cnt + 2;
    issue(0, 4'd2, 7'h21, 2, a);
    issue(1, 4'd9, 7'h31, 2, a);
    check("b2b_accept_in_done", a, 1);
    @(negedge clk);
    check("b2b_dpr_next_cycle", {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o}, {3'b111, 2'd1, 8'h09});
    wait_done(tgt);

    // async reset during the second data byte
    d_before = done_cnt;
    begin
      int base, n;
      base = ops_seen;
      issue(0, 4'd3, 7'h22, 4, a);
      n = 0;
      while (ops_seen < base + 8 && n < 5000) begin @(negedge clk); n++; end
      check("reached_byte2", ops_seen >= base + 8, 1);
    end
    @(posedge clk); #2;
    rst = 1; #1;
    check("rst_async_wb", {wb_cyc_o, wb_stb_o}, 0);
    check("rst_async_ready", req_ready, 0);
    exp_ops.delete(); exp_st.delete(); exp_rd.delete(); wr_q.delete(); rd_src.delete();
    push_op(2'd0, 8'hC0);
    repeat (3) @(negedge clk);
    rst = 0;
    wait_ready();
    check("reinit_csr_written", exp_ops.size(), 0);
    check("no_done_after_abort", done_cnt, d_before);
    run_req(0, 4'd3, 7'h22, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end
endmodule

// File: doc/i2cmb_cmd_sequencer.md
# i2cmb_cmd_sequencer

Hardware command sequencer that drives the I2CMB core's Wishbone slave port on behalf of one byte-stream requester. It converts a high-level request (bus, 7-bit address, direction, length) into the CSR/DPR/CMDR register-access sequence: SET_BUS, START, address, data bytes, STOP. It waits for each command to complete via the core's `irq`, decodes the CMDR status, and reports one completion code per request. It replaces software/BFM register sequencing in system-level configurations.

## Interface
- `TIMEOUT_CYCLES`, 100000: max cycles waiting for `irq_i` after any CMDR write.
- `CSR_INIT`, 8'hC0: CSR value written at init (E=1, IE=1).
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: sequencer idle; request accepted when `req_valid & req_ready`.
- `req_rw` in 1: 0 write, 1 read.
- `req_bus` in 4: I2C bus index.
- `req_addr` in 7: slave address.
- `req_len` in 6: data bytes, 0..63; 0 = address-only probe.
- `wr_data` in 8, `wr_valid` in 1, `wr_ready` out 1: write byte stream.
- `rd_data` out 8, `rd_valid` out 1, `rd_ready` in 1: read byte stream.
- `done` out 1: one-cycle completion pulse.
- `status` out 3: valid with `done`. 0 OK, 1 NAK_ADDR, 2 NAK_DATA, 3 ARB_LOST, 4 ERR, 5 TIMEOUT.
- `wb_adr_o` out 2, `wb_dat_o` out 8, `wb_we_o` out 1, `wb_cyc_o` out 1, `wb_stb_o` out 1: Wishbone master.
- `wb_dat_i` in 8, `wb_ack_i` in 1: Wishbone master returns.
- `irq_i` in 1: I2CMB interrupt.

## Operation
- Register offsets: CSR 0, DPR 1, CMDR 2. CMDR codes: WAIT 0, WRITE 1, READ_ACK 2, READ_NAK 3, START 4, STOP 5, SET_BUS 6.
- INIT, entered after reset: WB write CSR=`CSR_INIT`, then IDLE.
- IDLE: `req_ready`=1. Capture all `req_*` fields on accept.
- Sequence:
  - DPR=bus, CMDR=SET_BUS, WAIT_DONE.
  - CMDR=START, WAIT_DONE.
  - DPR={addr,rw}, CMDR=WRITE, WAIT_DONE.
  - Then `req_len` byte phases, then CMDR=STOP, WAIT_DONE, then `done` with OK.
- Write byte phase: assert `wr_ready` until a `wr_valid` handshake. Latch the byte, then DPR=byte, CMDR=WRITE, WAIT_DONE.
- Read byte phase: CMDR=READ_ACK, or READ_NAK for the final byte; WAIT_DONE; WB read DPR. Hold `rd_valid`/`rd_data` until `rd_ready`, then advance.
- WAIT_DONE:
  - Wait for `irq_i`=1, then WB read CMDR (the read clears irq in the core).
  - Decode bits [7:4] with priority AL > ERR > NAK > DON.
  - DON: continue.
  - NAK on address: STOP, then `done`/NAK_ADDR. NAK on data: STOP, then NAK_DATA.
  - AL: no STOP; `done`/ARB_LOST.
  - ERR: no STOP; `done`/ERR.
  - None of the above: treat as ERR.
- Timeout: a counter loads 0 on each CMDR write and increments in WAIT_DONE. On reaching `TIMEOUT_CYCLES`:
  - WB write CSR=0x00, then CSR=`CSR_INIT`.
  - `done`/TIMEOUT, then IDLE.
- Byte counter is 6 bits, loaded with `req_len`, decremented per byte phase. The phase is last when the counter equals 1. A length of 0 goes directly from the address phase to STOP.

## Timing
- Reset values: all outputs 0 except `wb_adr_o`=0 and `wb_dat_o`=0; `req_ready`=0 until INIT completes.
- WB transaction: `cyc`/`stb`/`we`/`adr`/`dat` are registered and stable until `wb_ack_i` is sampled high. They deassert the following cycle. At least one idle cycle separates transactions.
- Read data is captured in the `wb_ack_i` cycle.
- `done` asserts the cycle after the final WB access completes. `req_ready` rises in that same cycle.
- Back-to-back: a request accepted in the `done` cycle starts SET_BUS DPR write the next cycle.
- `irq_i` asserted before WAIT_DONE is entered still counts; it is level-sampled.
- Async reset mid-transfer aborts immediately: WB strobes drop, state goes to INIT, no `done`. The I2C bus may be left busy; the INIT CSR write recovers the core.
- `wr_valid` while not in a write byte phase is ignored (`wr_ready`=0).

## Test plan
- Write, bus 2, addr 0x22, len 3, bytes A5/5A/FF → WB sequence DPR=02, CMDR=06, CMDR=04, DPR=0x44, CMDR=01, then per byte DPR/CMDR=01, then CMDR=05; slave sees three bytes; `status`=0.
- Read, addr 0x22, len 2, slave returns 0x11,0x22 → CMDR=02 then CMDR=03; `rd_data` 0x11, 0x22 in order; `rd_ready` held low 5 cycles stalls without loss.
- Address NAK (addr 0x7F, no slave) → STOP issued, no byte phases, `status`=1; data NAK on 2nd byte → STOP, `status`=2.
- len=0 probe → START, address, STOP only; `status`=0.
- `irq_i` never asserted, `TIMEOUT_CYCLES`=50 → `done` 50 cycles after CMDR write plus CSR=00 and CSR=C0 writes; `status`=5.
- Assert `rst_i` during data byte 2 → WB strobes low asynchronously; CSR=C0 rewritten; next request completes OK.
